// File: rtl/imem_boot_ctrl_if.sv
// Host byte link and instruction-memory write port of the boot sequencer.
// master = sequencer side, slave = host/memory side.
interface imem_boot_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;

  modport master (
    input  rx_valid, rx_data,
    output rx_ready, imem_we, imem_waddr, imem_wdata
  );

  modport slave (
    output rx_valid, rx_data,
    input  rx_ready, imem_we, imem_waddr, imem_wdata
  );
endinterface

// File: rtl/imem_boot_ctrl.sv
// Boot and run-control sequencer: packs a little-endian host byte stream into
// instruction memory words, pulses the PC reset, then gates the core clock enable.
module imem_boot_ctrl #(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] START_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              abort,
  imem_boot_ctrl_if.master  bus,
  output logic              pc_reset,
  output logic [31:0]       pc_init,
  output logic              cpu_run,
  input  logic              cpu_halt,
  output logic              halted,
  output logic              err,
  output logic [31:0]       run_cycles
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, RUN, HALT} state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W:0]   words_left;
  logic [ADDR_W-1:0] waddr;
  logic [1:0]        byte_cnt;
  logic [23:0]       word_buf;

  logic can_start;
  logic len_bad;
  logic accept;

  assign can_start = (state == IDLE) || (state == HALT);
  assign len_bad   = (len > DEPTH);
  assign accept    = bus.rx_valid && bus.rx_ready;
  assign pc_init   = START_PC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, HALT: begin
        if (start && (len == '0)) begin
          state_next = FLUSH;
        end else if (start && !len_bad) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (accept && (byte_cnt == 2'd3) && (words_left == (ADDR_W+1)'(1))) begin
          state_next = FLUSH;
        end
      end
      FLUSH: state_next = RUN;
      RUN: begin
        if (cpu_halt) begin
          state_next = HALT;
        end
      end
      default: state_next = IDLE;
    endcase
    // abort overrides every other transition, including a completing last byte
    if (abort) begin
      state_next = IDLE;
    end
  end

  always_comb begin
    bus.rx_ready = (state == LOAD);
    pc_reset     = (state == FLUSH);
    cpu_run      = (state == RUN);
    halted       = (state == HALT);
  end

  // Bytes shift into word_buf so that after three bytes lane 0 sits in bits 7:0;
  // the 4th byte completes the word and is written one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_left     <= '0;
      waddr          <= '0;
      byte_cnt       <= '0;
      word_buf       <= '0;
      err            <= 1'b0;
      run_cycles     <= '0;
      bus.imem_we    <= 1'b0;
      bus.imem_waddr <= '0;
      bus.imem_wdata <= '0;
    end else begin
      bus.imem_we <= 1'b0;
      if (!abort) begin
        if (can_start && start) begin
          if (len_bad) begin
            err <= 1'b1;
          end else begin
            err        <= 1'b0;
            words_left <= len;
            waddr      <= '0;
            byte_cnt   <= '0;
          end
        end
        if (accept) begin
          byte_cnt <= byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            bus.imem_we    <= 1'b1;
            bus.imem_waddr <= waddr;
            bus.imem_wdata <= {bus.rx_data, word_buf};
            waddr          <= waddr + ADDR_W'(1);
            words_left     <= words_left - (ADDR_W+1)'(1);
          end else begin
            word_buf <= {bus.rx_data, word_buf[23:8]};
          end
        end
      end
      if (state == FLUSH) begin
        run_cycles <= '0;
      end else if ((state == RUN) && (run_cycles != 32'hFFFF_FFFF)) begin
        run_cycles <= run_cycles + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Self-checking bench for imem_boot_ctrl: expected memory writes are queued as
// bytes are driven and popped by a monitor when the write strobe appears.
module tb_imem_boot_ctrl;

  localparam int          ADDR_W   = 10;
  localparam int          DEPTH    = 1 << ADDR_W;
  localparam logic [31:0] START_PC = 32'h0000_0000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   len = '0;
  logic              abort = 1'b0;
  logic              cpu_halt = 1'b0;
  logic              pc_reset;
  logic [31:0]       pc_init;
  logic              cpu_run;
  logic              halted;
  logic              err;
  logic [31:0]       run_cycles;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    int                cyc;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        mon_e;
  logic [7:0] image [12];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         n_writes = 0;
  int         n_pc = 0;
  int         nw0;
  int         np0;

  imem_boot_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  imem_boot_ctrl #(.ADDR_W(ADDR_W), .START_PC(START_PC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .abort      (abort),
    .bus        (bus),
    .pc_reset   (pc_reset),
    .pc_init    (pc_init),
    .cpu_run    (cpu_run),
    .cpu_halt   (cpu_halt),
    .halted     (halted),
    .err        (err),
    .run_cycles (run_cycles)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [ADDR_W:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
    len   = '0;
  endtask

  // Drive image[first +: count]; gap idle cycles separate consecutive bytes.
  task automatic send_bytes(input int first, input int count, input int gap, input int base);
    for (int i = 0; i < count; i++) begin
      if (i > 0) repeat (gap) tick();
      bus.rx_valid = 1'b1;
      bus.rx_data  = image[first+i];
      checkOutput("rx_ready", bus.rx_ready, 1);
      if ((i % 4) == 3) begin
        exp_q.push_back('{addr: ADDR_W'(base + i/4),
                          data: {image[first+i], image[first+i-1], image[first+i-2], image[first+i-3]},
                          cyc:  cyc + 1});
      end
      tick();
      bus.rx_valid = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      n_writes++;
      checkOutput("we_expected", 64'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        checkOutput("waddr", bus.imem_waddr, mon_e.addr);
        checkOutput("wdata", bus.imem_wdata, mon_e.data);
        checkOutput("wcycle", cyc, mon_e.cyc);
      end
    end
    if (pc_reset === 1'b1) n_pc++;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    image = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h00, 8'h40, 8'h01, 8'h13, 8'h01, 8'hB0, 8'hFF};
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;

    $display("[TB] reset values");
    tick();
    tick();
    checkOutput("rst_rx_ready", bus.rx_ready, 0);
    checkOutput("rst_we", bus.imem_we, 0);
    checkOutput("rst_waddr", bus.imem_waddr, 0);
    checkOutput("rst_wdata", bus.imem_wdata, 0);
    checkOutput("rst_pc_reset", pc_reset, 0);
    checkOutput("rst_cpu_run", cpu_run, 0);
    checkOutput("rst_halted", halted, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_run_cycles", run_cycles, 0);
    rst_n = 1'b1;
    tick();

    $display("[TB] full-rate load of 3 words");
    applyStimulus((ADDR_W+1)'(3));
    send_bytes(0, 12, 0, 0);
    checkOutput("flush_pc_reset", pc_reset, 1);
    checkOutput("flush_pc_init", pc_init, START_PC);
    checkOutput("flush_rx_ready", bus.rx_ready, 0);
    checkOutput("flush_cpu_run", cpu_run, 0);
    tick();
    checkOutput("run_cpu_run", cpu_run, 1);
    checkOutput("run_pc_reset", pc_reset, 0);

    $display("[TB] stalled load of 3 words");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort_cpu_run", cpu_run, 0);
    applyStimulus((ADDR_W+1)'(3));
    send_bytes(0, 12, 1, 0);
    checkOutput("flush2_pc_reset", pc_reset, 1);
    tick();
    checkOutput("run2_cpu_run", cpu_run, 1);
    checkOutput("run2_cycles0", run_cycles, 0);

    $display("[TB] halt after 100 run cycles, then restart");
    repeat (99) tick();
    cpu_halt = 1'b1;
    tick();
    cpu_halt = 1'b0;
    checkOutput("halt_halted", halted, 1);
    checkOutput("halt_cpu_run", cpu_run, 0);
    checkOutput("halt_run_cycles", run_cycles, 100);
    repeat (3) tick();
    checkOutput("halt_hold_cycles", run_cycles, 100);
    applyStimulus('0);
    checkOutput("restart_pc_reset", pc_reset, 1);
    checkOutput("restart_halted", halted, 0);
    tick();
    checkOutput("restart_cpu_run", cpu_run, 1);
    checkOutput("restart_cycles0", run_cycles, 0);
    tick();
    checkOutput("restart_cycles1", run_cycles, 1);

    $display("[TB] abort mid-load");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    nw0 = n_writes;
    np0 = n_pc;
    applyStimulus((ADDR_W+1)'(2));
    send_bytes(0, 6, 0, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort_rx_ready", bus.rx_ready, 0);
    repeat (4) tick();
    checkOutput("abort_writes", n_writes - nw0, 1);
    checkOutput("abort_pc_pulses", n_pc - np0, 0);
    checkOutput("abort_idle_run", cpu_run, 0);
    checkOutput("abort_idle_halted", halted, 0);

    $display("[TB] bad length then valid single-word load");
    applyStimulus((ADDR_W+1)'(DEPTH + 1));
    checkOutput("badlen_err", err, 1);
    checkOutput("badlen_rx_ready", bus.rx_ready, 0);
    checkOutput("badlen_pc_reset", pc_reset, 0);
    applyStimulus((ADDR_W+1)'(1));
    checkOutput("goodlen_err", err, 0);
    checkOutput("goodlen_rx_ready", bus.rx_ready, 1);
    send_bytes(0, 4, 0, 0);
    checkOutput("single_pc_reset", pc_reset, 1);
    tick();
    checkOutput("single_cpu_run", cpu_run, 1);

    $display("[TB] asynchronous reset mid-run");
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("areset_cpu_run", cpu_run, 0);
    checkOutput("areset_run_cycles", run_cycles, 0);
    checkOutput("areset_rx_ready", bus.rx_ready, 0);
    tick();
    #2;
    rst_n = 1'b1;
    tick();
    checkOutput("post_rst_cpu_run", cpu_run, 0);
    checkOutput("post_rst_halted", halted, 0);
    applyStimulus('0);
    checkOutput("post_rst_pc_reset", pc_reset, 1);
    tick();
    checkOutput("post_rst_run", cpu_run, 1);

    repeat (3) tick();
    checkOutput("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_boot_ctrl.md
# imem_boot_ctrl

Boot and run-control sequencer for the single-stage RV core. It accepts a little-endian byte stream from a host link and packs it into 32-bit words written to instruction memory. It then forces the PC to the start address and releases the core, and it holds the core stalled on halt or abort. It replaces the simulation-only memory preload and PC initialisation, so the same image-load path works in simulation and on hardware.

## Interface
Parameters:
- ADDR_W, 10: instruction memory word-address width; DEPTH = 2**ADDR_W words.
- START_PC, 32'h0000_0000: value driven on pc_init during the PC reset pulse.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle load/run request; honoured only in IDLE or HALT.
- len  in  ADDR_W+1  word count sampled with start; 0 = run the existing image without loading.
- abort  in  1  force return to IDLE from any state.
- rx_valid  in  1  host byte valid.
- rx_data  in  8  host byte.
- rx_ready  out  1  byte accepted when rx_valid && rx_ready.
- imem_we  out  1  instruction memory write strobe, one cycle per word.
- imem_waddr  out  ADDR_W  word address.
- imem_wdata  out  32  word data.
- pc_reset  out  1  one-cycle pulse; the core loads pc_init into next_pc.
- pc_init  out  32  equals START_PC.
- cpu_run  out  1  core clock-enable; the core holds all state when low.
- cpu_halt  in  1  halt request from the core (ebreak/ecall decode).
- halted  out  1  high in HALT.
- err  out  1  sticky bad-length flag.
- run_cycles  out  32  cycles spent in RUN since the last FLUSH; saturates at 32'hFFFF_FFFF.

## Operation
- States: IDLE, LOAD, FLUSH, RUN, HALT. Reset state is IDLE.
- Reset values: rx_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, pc_reset=0, cpu_run=0, halted=0, err=0, run_cycles=0.
- IDLE/HALT, start with 0<len<=DEPTH: go to LOAD. Latch words_left=len, clear waddr and byte lane, clear err.
- IDLE/HALT, start with len==0: go to FLUSH and clear err.
- IDLE/HALT, start with len>DEPTH: stay in the current state and set err. err stays set until the next accepted start.
- LOAD: rx_ready=1. Each accepted byte fills lane byte_cnt (lane 0 = bits 7:0).
  - On the 4th byte, write the assembled word at waddr in the next cycle. Then increment waddr and decrement words_left.
  - The byte stream may stall with rx_valid low for any number of cycles; no timeout.
- When the last byte of the last word is accepted, go to FLUSH. rx_ready drops in that same next cycle.
- FLUSH: lasts one cycle with pc_reset=1 and run_cycles cleared, then goes to RUN.
- RUN: cpu_run=1 and run_cycles increments each cycle. cpu_halt=1 goes to HALT, and cpu_run is 0 from the next cycle. start is ignored in RUN.
- HALT: cpu_run=0, halted=1. Memory and PC are untouched. run_cycles holds its value.
- abort, any state: go to IDLE on the next edge.
  - A partially assembled word is discarded and is never written.
  - Words already written stay in memory.
  - abort has priority over start, cpu_halt and byte acceptance in the same cycle.
- waddr wraps only by reaching DEPTH, which the length check makes unreachable.
- Reset asserted mid-LOAD or mid-RUN: all outputs take their reset values immediately (asynchronous). Memory contents are not cleared.

## Timing
- Byte acceptance has zero wait states: one byte per cycle at full rate.
- Word write latency: if the 4th byte is accepted in cycle N, imem_we is high in cycle N+1 only, with that word's address and data.
- Last word: its imem_we and pc_reset are both high in the same cycle N+1, in FLUSH. cpu_run is high from N+2.
- start with len==0 in cycle S: pc_reset is high in S+1 and cpu_run is high from S+2.
- cpu_halt in cycle H during RUN: run_cycles includes cycle H, and cpu_run is 0 from H+1.
- Minimum load of L words at full byte rate: 4L cycles of rx_ready, then FLUSH, then RUN.

## Test plan
- Reset, then start len=3 followed by 12 bytes 13 05 A0 00 93 00 40 01 13 01 B0 FF. Required:
  - imem writes addr0=32'h00A00513, addr1=32'h01400093, addr2=32'hFFB00113, each one cycle after the word's 4th byte;
  - pc_reset pulse with pc_init=0;
  - cpu_run high from 2 cycles after the last byte.
- Same load with rx_valid low every other cycle: identical writes, with write timing still one cycle after each 4th byte.
- In RUN, assert cpu_halt after 100 RUN cycles. Required: halted=1, cpu_run=0 next cycle, run_cycles=100. Then start len=0: pc_reset pulse, run_cycles=0, then counting resumes.
- Assert abort after 6 bytes of a len=2 load. Required: exactly one imem write (addr0), IDLE, rx_ready=0, no pc_reset.
- start len=DEPTH+1 in IDLE: state stays IDLE and err=1. Then start len=1: err=0 and LOAD entered.
- Drop rst_n mid-RUN asynchronously: cpu_run=0 and run_cycles=0 before the next clock edge. State is IDLE after release.
